// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder and the downstream up/down counter.
package quad_pkg;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_INC  = 2'b01;
  localparam logic [1:0] CTRL_DEC  = 2'b10;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Next {A,B} code in the forward direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_fwd(input logic [1:0] g);
    case (g)
      2'b00:   gray_fwd = 2'b01;
      2'b01:   gray_fwd = 2'b11;
      2'b11:   gray_fwd = 2'b10;
      default: gray_fwd = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Quadrature input / step-command bundle between the encoder front end and the decoder.
interface quad_step_decoder_if;
  logic       en_i;
  logic       a_i;
  logic       b_i;
  logic [1:0] control_o;
  logic       err_o;

  modport master (output en_i, a_i, b_i, input control_o, err_o);
  modport slave  (input en_i, a_i, b_i, output control_o, err_o);
endinterface

// File: rtl/quad_glitch_filter.sv
// One quadrature channel: metastability synchroniser followed by a stability filter.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic d_i,
  output logic sync_o,
  output logic filt_o
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign sync_o = sync;
  assign filt_o = filt_q;

  // A new level is taken only after it has disagreed with the filtered level
  // on FILT_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (load_i) begin
      filt_d = sync;
      cnt_d  = '0;
    end else if (sync != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filters A/B, decodes Gray sub-steps, accumulates them and
// emits one-cycle INC/DEC commands for the up/down counter.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_CYCLES   = 4,
  parameter int STEPS_PER_CNT = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  quad_step_decoder_if.slave bus
);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0]     FILL_LAST = FW'(SYNC_STAGES - 1);
  localparam logic signed [3:0] STEP_P    = 4'(STEPS_PER_CNT);
  localparam logic signed [3:0] STEP_N    = -STEP_P;

  state_e            state_q, state_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              load;
  logic [1:0]        raw_ab, sync_ab, filt_ab;
  logic [1:0]        prev_q, prev_d;
  logic signed [2:0] acc_q, acc_d;
  logic signed [3:0] sub, sum;
  logic              bad;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              err_q, err_d;

  assign raw_ab        = {bus.a_i, bus.b_i};
  assign bus.control_o = ctrl_q;
  assign bus.err_o     = err_q;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    quad_glitch_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_filt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .d_i    (raw_ab[g]),
      .sync_o (sync_ab[g]),
      .filt_o (filt_ab[g])
    );
  end

  // FILL waits for the synchroniser to hold real input levels before LOAD seeds
  // filtered and prev with them, so reset never produces a pulse or error.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    load    = 1'b0;
    case (state_q)
      ST_FILL: begin
        fill_d = fill_q + FW'(1);
        if (fill_q == FILL_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    sub = 4'sd0;
    bad = 1'b0;
    if (filt_ab == prev_q)                sub = 4'sd0;
    else if (filt_ab == gray_fwd(prev_q)) sub = 4'sd1;
    else if (prev_q == gray_fwd(filt_ab)) sub = -4'sd1;
    else                                  bad = 1'b1;
    sum = {acc_q[2], acc_q} + sub;

    prev_d = load ? sync_ab : filt_ab;
    acc_d  = '0;
    ctrl_d = CTRL_IDLE;
    err_d  = 1'b0;
    if (state_q == ST_RUN && bus.en_i) begin
      acc_d = acc_q;
      if (bad) begin
        err_d = 1'b1;
      end else if (sum == STEP_P) begin
        ctrl_d = CTRL_INC;
        acc_d  = '0;
      end else if (sum == STEP_N) begin
        ctrl_d = CTRL_DEC;
        acc_d  = '0;
      end else begin
        acc_d = sum[2:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      ctrl_q  <= CTRL_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench: two decoders (1 and 4 Gray edges per command) share one random stimulus and
// are checked every cycle against a position-arithmetic model, plus literal checks.
module tb_quad_step_decoder;
  import quad_pkg::*;

  localparam int SYNC   = 2;
  localparam int FILT   = 4;
  localparam int STEPS0 = 1;
  localparam int STEPS1 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  logic a     = 1'b1;
  logic b     = 1'b1;

  quad_step_decoder_if bus0 ();
  quad_step_decoder_if bus1 ();
  assign bus0.en_i = en;
  assign bus0.a_i  = a;
  assign bus0.b_i  = b;
  assign bus1.en_i = en;
  assign bus1.a_i  = a;
  assign bus1.b_i  = b;

  quad_step_decoder #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .STEPS_PER_CNT(STEPS0))
    dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  quad_step_decoder #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .STEPS_PER_CNT(STEPS1))
    dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int steps_of(input int i);
    return (i == 0) ? STEPS0 : STEPS1;
  endfunction

  function automatic int gpos(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [1:0] pipe[$];       // raw samples waiting in the synchroniser
  logic [1:0] m_filt, m_prev;
  int         mis_run [2];   // consecutive cycles the synced level disagreed
  int         acc     [2];
  int         edge_n;
  logic [1:0] exp_ctrl[2];
  logic       exp_err [2];

  task automatic model_reset();
    pipe = {};
    for (int i = 0; i < SYNC; i++) pipe.push_back(2'b00);
    m_filt = 2'b00; m_prev = 2'b00; edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      mis_run[i] = 0; acc[i] = 0; exp_ctrl[i] = CTRL_IDLE; exp_err[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [1:0] s;
    int         d;
    s = pipe.pop_front();
    pipe.push_back({a, b});
    edge_n++;
    for (int i = 0; i < 2; i++) begin exp_ctrl[i] = CTRL_IDLE; exp_err[i] = 1'b0; end
    if (edge_n == SYNC + 1) begin
      m_filt = s; m_prev = s; mis_run[0] = 0; mis_run[1] = 0;
    end else if (edge_n > SYNC + 1) begin
      d = (gpos(m_filt) - gpos(m_prev)) & 3;
      for (int i = 0; i < 2; i++) begin
        if (!en) acc[i] = 0;
        else if (d == 2) exp_err[i] = 1'b1;
        else begin
          acc[i] += (d == 1) ? 1 : (d == 3) ? -1 : 0;
          if (acc[i] == steps_of(i)) begin exp_ctrl[i] = CTRL_INC; acc[i] = 0; end
          else if (acc[i] == -steps_of(i)) begin exp_ctrl[i] = CTRL_DEC; acc[i] = 0; end
        end
      end
      m_prev = m_filt;
      for (int c = 0; c < 2; c++) begin
        if (s[c] != m_filt[c]) begin
          mis_run[c]++;
          if (mis_run[c] == FILT) begin m_filt[c] = s[c]; mis_run[c] = 0; end
        end else mis_run[c] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  int inc_seen[2] = '{0, 0};
  int dec_seen[2] = '{0, 0};
  int err_seen[2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("ctrl0", int'(bus0.control_o), int'(exp_ctrl[0]));
      check("err0",  int'(bus0.err_o),     int'(exp_err[0]));
      check("ctrl1", int'(bus1.control_o), int'(exp_ctrl[1]));
      check("err1",  int'(bus1.err_o),     int'(exp_err[1]));
      if (bus0.control_o == CTRL_INC) inc_seen[0]++;
      if (bus0.control_o == CTRL_DEC) dec_seen[0]++;
      if (bus0.err_o) err_seen[0]++;
      if (bus1.control_o == CTRL_INC) inc_seen[1]++;
      if (bus1.control_o == CTRL_DEC) dec_seen[1]++;
      if (bus1.err_o) err_seen[1]++;
    end
  end

  // ---------------- stimulus ----------------
  int pos = 2;  // position whose Gray code is 11

  task automatic go(input int p, input int hold);
    pos = p;
    {a, b} = gcode(p);
    repeat (hold) @(negedge clk);
  endtask

  // Called at a negedge; returns edges until the STEPS=1 decoder shows INC.
  task automatic step_lat(input int p, output int lat);
    pos = p;
    {a, b} = gcode(p);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus0.control_o == CTRL_INC && lat < 0) lat = k;
    end
    @(negedge clk);
  endtask

  int i0, d0, e0, i1, d1, e1, lat, got, act;

  task automatic snap();
    i0 = inc_seen[0]; d0 = dec_seen[0]; e0 = err_seen[0];
    i1 = inc_seen[1]; d1 = dec_seen[1]; e1 = err_seen[1];
  endtask

  initial begin
    // Reset with both channels high: no pulse, no error.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    check("rst_idle_pulses", inc_seen[0] + dec_seen[0] + inc_seen[1] + dec_seen[1] - i0 - d0 - i1 - d1, 0);
    check("rst_idle_err", err_seen[0] + err_seen[1] - e0 - e1, 0);

    // Walk to 00 legally, clear the accumulators, then one full forward cycle.
    go(3, 10); go(4, 10);
    en = 1'b0; repeat (3) @(negedge clk); en = 1'b1;
    snap();
    for (int s = 1; s <= 4; s++) begin
      step_lat(4 + s, lat);
      check($sformatf("lat_step%0d", s), lat, SYNC + FILT + 1);
    end
    check("fwd_inc_steps1", inc_seen[0] - i0, 4);
    check("fwd_inc_steps4", inc_seen[1] - i1, 1);

    // Two forward, two back: no command at 4 edges per count.
    snap();
    go(pos + 1, 10); go(pos + 1, 10); go(pos - 1, 10); go(pos - 1, 10);
    check("wiggle_steps4", inc_seen[1] + dec_seen[1] - i1 - d1, 0);
    check("wiggle_inc_steps1", inc_seen[0] - i0, 2);
    check("wiggle_dec_steps1", dec_seen[0] - d0, 2);

    // Full reverse cycle: one DEC at 4 edges per count.
    snap();
    for (int s = 0; s < 4; s++) go(pos - 1, 10);
    check("rev_dec_steps4", dec_seen[1] - d1, 1);
    check("rev_dec_steps1", dec_seen[0] - d0, 4);

    // Now at 00. Short glitch on A is rejected; a FILT-long pulse is one step each way.
    snap();
    a = 1'b1; repeat (FILT - 1) @(negedge clk); a = 1'b0; repeat (12) @(negedge clk);
    check("glitch_rejected", inc_seen[0] + dec_seen[0] + err_seen[0] - i0 - d0 - e0, 0);
    snap();
    a = 1'b1; repeat (FILT) @(negedge clk); a = 1'b0; repeat (12) @(negedge clk);
    check("pulse_dec", dec_seen[0] - d0, 1);
    check("pulse_inc", inc_seen[0] - i0, 1);

    // 00 -> 11 in one cycle: single error pulse, no command; then 11 -> 10 steps normally.
    snap();
    go(2, 12);
    check("dbl_err_cnt", err_seen[0] - e0, 1);
    check("dbl_no_cmd", inc_seen[0] + dec_seen[0] - i0 - d0, 0);
    snap();
    go(3, 12);
    check("resync_inc", inc_seen[0] - i0, 1);
    check("resync_err", err_seen[0] - e0, 0);

    // Motion with decode disabled: nothing during, nothing on re-enable.
    snap();
    en = 1'b0;
    go(pos + 1, 8); go(pos + 1, 8); go(pos + 1, 8);
    en = 1'b1;
    repeat (20) @(negedge clk);
    check("en_off_no_burst", inc_seen[0] + dec_seen[0] + inc_seen[1] + dec_seen[1] - i0 - d0 - i1 - d1, 0);

    // Asynchronous reset while a command is on the output.
    pos = pos + 1; {a, b} = gcode(pos);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(posedge clk); #1;
      if (bus0.control_o != CTRL_IDLE) got = 1;
    end
    check("rst_wait_cmd", got, 1);
    #2 rst_n = 1'b0;
    #1;
    act = int'(bus0.control_o); check("async_rst_ctrl0", act, 0);
    act = int'(bus1.control_o); check("async_rst_ctrl1", act, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Random motion, glitches, double jumps and enable toggles.
    for (int it = 0; it < 350; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      go(pos + (($urandom_range(0, 1) == 1) ? 1 : -1), int'($urandom_range(1, 10)));
      else if (r < 78) go(pos + 2, int'($urandom_range(2, 10)));
      else if (r < 88) begin
        if ($urandom_range(0, 1) == 1) a = ~a; else b = ~b;
        repeat (int'($urandom_range(1, 6))) @(negedge clk);
        {a, b} = gcode(pos);
        repeat (int'($urandom_range(1, 8))) @(negedge clk);
      end else begin
        en = ~en;
        repeat (int'($urandom_range(1, 6))) @(negedge clk);
      end
    end
    en = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
